mem_bank_rw: RTL and testbench

- Parametrised single-port data memory bank, the next generation of the processor's scratch/data store.
- Adds configurable width and depth, per-byte write strobes, and a valid/ready request port with a registered response.
- Read-during-write mode is selected per request.
- Adds a hardware clear sweep: after reset and on demand, the bank zeroes itself one word per cycle while stalling requests.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_clear_seq.sv | 58 +++++
 rtl/mem_bank_rw.sv | 121 ++++++++++++
 tb/tb_mem_bank_rw.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, mode encodings and the byte-merge helper for the data memory bank.
package mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic MODE_WRITE_FIRST = 1'b0;
    localparam logic MODE_READ_FIRST  = 1'b1;

    // The merge runs at the widest supported word; callers zero-extend and truncate.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// CLEAR/READY sequencer: sweeps every word address once after reset or a clear pulse.
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int CNT_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] sweep_addr_o,
    output logic                 sweep_we_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output state_e               state_o
);

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    // A clear during the sweep restarts it from word 0.
                    if (clear_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_WIDTH'(DEPTH - 1)) begin
                        state_q <= READY;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                READY: begin
                    if (clear_i) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign sweep_addr_o = cnt_q;
    assign sweep_we_o   = (state_q == CLEAR);
    assign ready_o      = (state_q == READY);
    assign busy_o       = (state_q == CLEAR);
    assign state_o      = state_q;

endmodule

// File: rtl/mem_bank_rw.sv
// Single-port data memory bank with byte strobes, per-request read-during-write mode,
// one-cycle registered response and a self-clearing sweep.
module mem_bank_rw
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic                      req_mode,
    input  logic                      clear,
    output logic                      busy,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_err
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int IDX_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0]     cells [DEPTH];
    logic [IDX_WIDTH-1:0]      sweep_addr;
    logic                      sweep_we;
    state_e                    seq_state;
    logic                      accept;
    logic                      in_range;
    logic                      wr_en;
    logic [IDX_WIDTH-1:0]      idx;
    logic [DATA_WIDTH-1:0]     old_word;
    logic [DATA_WIDTH-1:0]     merged;
    logic [MAX_DATA_WIDTH-1:0] old_wide;
    logic [MAX_DATA_WIDTH-1:0] new_wide;
    logic [MAX_DATA_WIDTH-1:0] merged_wide;
    logic [MAX_BE_WIDTH-1:0]   be_wide;
    logic                      rsp_valid_q;
    logic [DATA_WIDTH-1:0]     rsp_data_q;
    logic [DATA_WIDTH-1:0]     rsp_data_d;
    logic                      rsp_err_q;
    logic                      unused_bits;

    mem_clear_seq #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (IDX_WIDTH)
    ) u_seq (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .sweep_addr_o (sweep_addr),
        .sweep_we_o   (sweep_we),
        .ready_o      (req_ready),
        .busy_o       (busy),
        .state_o      (seq_state)
    );

    // Valid/ready: a request transfers on a rising edge where req_valid and req_ready
    // are both high; it is answered by a single rsp_valid pulse on the next cycle.
    assign accept   = req_valid && req_ready;
    assign in_range = 32'(req_addr) < 32'(DEPTH);
    assign idx      = req_addr[IDX_WIDTH-1:0];
    assign old_word = cells[idx];
    assign wr_en    = accept && req_we && in_range;

    always_comb begin
        old_wide                   = '0;
        old_wide[DATA_WIDTH-1:0]   = old_word;
        new_wide                   = '0;
        new_wide[DATA_WIDTH-1:0]   = req_wdata;
        be_wide                    = '0;
        be_wide[BE_WIDTH-1:0]      = req_be;
        merged_wide                = byte_merge(old_wide, new_wide, be_wide);
    end

    assign merged = merged_wide[DATA_WIDTH-1:0];

    always_comb begin
        rsp_data_d = old_word;
        if (!in_range) begin
            rsp_data_d = '0;
        end else if (req_we && (req_mode == MODE_WRITE_FIRST)) begin
            rsp_data_d = merged;
        end
    end

    // Sweep and request writes never coincide: requests are only accepted in READY.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            cells[sweep_addr] <= '0;
        end else if (wr_en) begin
            cells[idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_data_q <= rsp_data_d;
                rsp_err_q  <= !in_range;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    assign unused_bits = &{1'b0, merged_wide[MAX_DATA_WIDTH-1:DATA_WIDTH], seq_state};

endmodule

// File: tb/tb_mem_bank_rw.sv
// Directed bench for mem_bank_rw: a 64-word bank and a 48-word bank share clock and reset.
module tb_mem_bank_rw;

    logic        clk;
    logic        rst;

    logic        a_valid, a_ready, a_we, a_mode, a_clear, a_busy;
    logic        a_rsp_valid, a_rsp_err;
    logic [3:0]  a_be;
    logic [6:0]  a_addr;
    logic [31:0] a_wdata, a_rsp_data;

    logic        b_valid, b_ready, b_we, b_mode, b_clear, b_busy;
    logic        b_rsp_valid, b_rsp_err;
    logic [3:0]  b_be;
    logic [5:0]  b_addr;
    logic [31:0] b_wdata, b_rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic        mode;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    mem_bank_rw #(.DATA_WIDTH(32), .DEPTH(64), .ADDR_WIDTH(7)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (a_valid),
        .req_ready (a_ready),
        .req_we    (a_we),
        .req_be    (a_be),
        .req_addr  (a_addr),
        .req_wdata (a_wdata),
        .req_mode  (a_mode),
        .clear     (a_clear),
        .busy      (a_busy),
        .rsp_valid (a_rsp_valid),
        .rsp_data  (a_rsp_data),
        .rsp_err   (a_rsp_err)
    );

    mem_bank_rw #(.DATA_WIDTH(32), .DEPTH(48), .ADDR_WIDTH(6)) u_dut48 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_we    (b_we),
        .req_be    (b_be),
        .req_addr  (b_addr),
        .req_wdata (b_wdata),
        .req_mode  (b_mode),
        .clear     (b_clear),
        .busy      (b_busy),
        .rsp_valid (b_rsp_valid),
        .rsp_data  (b_rsp_data),
        .rsp_err   (b_rsp_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0; a_mode = 0; a_clear = 0;
        b_valid = 0; b_we = 0; b_be = '0; b_addr = '0; b_wdata = '0; b_mode = 0; b_clear = 0;
    endtask

    // driver: one request on bank a (sel=0) or bank b (sel=1), returns the response
    task automatic do_req(input bit sel, input logic we, input logic [3:0] be,
                          input logic [6:0] addr, input logic [31:0] wdata, input logic mode,
                          output logic [31:0] d, output logic e);
        int n;
        @(negedge clk);
        if (!sel) begin
            a_valid = 1; a_we = we; a_be = be; a_addr = addr; a_wdata = wdata; a_mode = mode;
        end else begin
            b_valid = 1; b_we = we; b_be = be; b_addr = addr[5:0]; b_wdata = wdata; b_mode = mode;
        end
        n = 0;
        while (!(sel ? b_ready : a_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        check(sel ? "b_rsp_valid" : "a_rsp_valid", sel ? b_rsp_valid : a_rsp_valid, 1);
        d = sel ? b_rsp_data : a_rsp_data;
        e = sel ? b_rsp_err : a_rsp_err;
        a_valid = 0;
        b_valid = 0;
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        while (!a_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          n, nb, spurious;

        vecs[0]  = '{1'b0, 4'h0, 7'd5,   32'h0,        1'b0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 4'hF, 7'd3,   32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 7'd3,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 4'h5, 7'd3,   32'h11223344, 1'b1, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 7'd3,   32'h0,        1'b0, 32'hDE22BE44, 1'b0};
        vecs[5]  = '{1'b1, 4'h5, 7'd3,   32'h11223344, 1'b0, 32'hDE22BE44, 1'b0};
        vecs[6]  = '{1'b1, 4'h0, 7'd3,   32'hFFFFFFFF, 1'b0, 32'hDE22BE44, 1'b0};
        vecs[7]  = '{1'b0, 4'hF, 7'd3,   32'h0,        1'b1, 32'hDE22BE44, 1'b0};
        vecs[8]  = '{1'b1, 4'hF, 7'd63,  32'hCAFEF00D, 1'b1, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 4'h0, 7'd63,  32'h0,        1'b0, 32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b1, 4'hF, 7'd64,  32'h12345678, 1'b0, 32'h0000_0000, 1'b1};
        vecs[11] = '{1'b0, 4'h0, 7'd127, 32'h0,        1'b0, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 4'h0, 7'd0,   32'h0,        1'b0, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b1, 4'h8, 7'd10,  32'hAB123456, 1'b0, 32'hAB000000, 1'b0};

        idle_inputs();
        rst = 1'b0;
        #12;
        check("reset_rsp_valid", a_rsp_valid, 0);
        check("reset_rsp_data", a_rsp_data, 0);
        check("reset_rsp_err", a_rsp_err, 0);
        check("reset_busy", a_busy, 1);
        check("reset_req_ready", a_ready, 0);

        @(negedge clk);
        rst = 1'b1;
        n = 0; nb = 0;
        while (!a_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (b_ready && nb == 0) nb = n;
        end
        check("init_sweep_cycles_64", n, 64);
        check("init_sweep_cycles_48", nb, 48);
        check("busy_after_sweep", a_busy, 0);

        // table-driven vectors on the 64-word bank
        for (int i = 0; i < 14; i++) begin
            do_req(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].mode, d, e);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
        end

        do_req(0, 0, 4'h0, 7'd3, 32'h0, 0, d, e);
        @(posedge clk);
        #1;
        check("hold_rsp_valid", a_rsp_valid, 0);
        check("hold_rsp_data", a_rsp_data, 32'hDE22BE44);

        // 48-word bank: fill, out-of-range writes, then verify nothing aliased
        for (int i = 0; i < 48; i++) begin
            do_req(1, 1, 4'hF, 7'(i), 32'hB000_0000 | i, 0, d, e);
            check($sformatf("b_fill%0d", i), d, 32'hB000_0000 | i);
        end
        do_req(1, 1, 4'hF, 7'd50, 32'h12345678, 0, d, e);
        check("b_oor50_data", d, 0);
        check("b_oor50_err", e, 1);
        do_req(1, 1, 4'hF, 7'd48, 32'h87654321, 1, d, e);
        check("b_oor48_data", d, 0);
        check("b_oor48_err", e, 1);
        for (int i = 0; i < 48; i++) begin
            do_req(1, 0, 4'h0, 7'(i), 32'h0, 0, d, e);
            check($sformatf("b_read%0d_data", i), d, 32'hB000_0000 | i);
            check($sformatf("b_read%0d_err", i), e, 0);
        end

        // clear collides with an accepted write; a read is then held through the sweep
        @(negedge clk);
        check("coll_ready", a_ready, 1);
        a_valid = 1; a_we = 1; a_be = 4'hF; a_addr = 7'd7; a_wdata = 32'hAAAA5555; a_mode = 0;
        a_clear = 1;
        @(posedge clk);
        #1;
        check("coll_rsp_valid", a_rsp_valid, 1);
        check("coll_rsp_data", a_rsp_data, 32'hAAAA5555);
        check("coll_rsp_err", a_rsp_err, 0);
        check("coll_busy", a_busy, 1);
        a_clear = 0; a_we = 0;
        n = 0; spurious = 0;
        while (!a_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (a_rsp_valid) spurious++;
        end
        check("coll_sweep_cycles", n, 64);
        check("coll_no_rsp_during_sweep", spurious, 0);
        @(posedge clk);
        #1;
        check("held_rsp_valid", a_rsp_valid, 1);
        check("held_rsp_data", a_rsp_data, 0);
        a_valid = 0;
        do_req(0, 0, 4'h0, 7'd3, 32'h0, 0, d, e);
        check("cleared_addr3", d, 0);

        // reset with a response pending
        do_req(0, 1, 4'hF, 7'd3, 32'h5A5A5A5A, 0, d, e);
        check("wr_5a_data", d, 32'h5A5A5A5A);
        @(negedge clk);
        a_valid = 1; a_we = 0; a_addr = 7'd3;
        @(posedge clk);
        #1;
        check("pend_rsp_valid", a_rsp_valid, 1);
        check("pend_rsp_data", a_rsp_data, 32'h5A5A5A5A);
        a_valid = 0;
        #1 rst = 1'b0;
        #1;
        check("pend_rst_rsp_valid", a_rsp_valid, 0);
        check("pend_rst_rsp_data", a_rsp_data, 0);
        check("pend_rst_busy", a_busy, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // reset at sweep cycle 20, held for two cycles
        repeat (20) @(posedge clk);
        #1;
        check("mid_sweep_busy", a_busy, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_rsp_valid", a_rsp_valid, 0);
        check("mid_rst_ready", a_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        count_sweep(n);
        check("restart_sweep_cycles", n, 64);
        do_req(0, 0, 4'h0, 7'd3, 32'h0, 0, d, e);
        check("after_restart_addr3", d, 0);
        check("after_restart_err", e, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
